// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Purpose : Shared encodings for the universal shift register.
//           - Mode selects how a shift is performed: logic, rotate, arithmetic,
//             or hold.
//           - Dir selects the shift direction.
// Ports   : none (package only)
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam logic [1:0] MODE_LOGIC  = 2'b00;
    localparam logic [1:0] MODE_ROTATE = 2'b01;
    localparam logic [1:0] MODE_ARITH  = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_bit_counter.sv
// -----------------------------------------------------------------------------
// shift_bit_counter
// Purpose : Counts effective shifts since the last clear and saturates at MAX.
//           o_done pulses for one cycle on the same edge where the count
//           reaches MAX. After saturation, o_done stays low until a clear.
// Ports   : i_clk    clock
//           i_rst    synchronous active-high reset
//           i_clear  restart the count (parallel load); has priority over i_inc
//           i_inc    one effective shift this cycle
//           o_count  shifts since last clear, saturating at MAX
//           o_done   one-cycle pulse when o_count reaches MAX
// -----------------------------------------------------------------------------
module shift_bit_counter #(
    parameter int MAX = 8,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_inc,
    output logic [CW-1:0] o_count,
    output logic          o_done
);

    localparam logic [CW-1:0] LAST = CW'(MAX - 1);
    localparam logic [CW-1:0] FULL = CW'(MAX);

    logic [CW-1:0] r_count;
    logic          r_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            // The pulse only fires on the LAST->FULL transition, so a
            // saturated counter never re-fires.
            r_done <= i_inc && (r_count == LAST);
            if (i_inc && (r_count != FULL))
                r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_done  = r_done;

endmodule

// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
// Purpose : WIDTH-bit register for serializer/deserializer and bit-manipulation
//           use. It supports parallel load; logic, rotate and arithmetic
//           shifts in either direction; and a hold mode. A counter reports
//           shifts since the last load and pulses Done when a full word has
//           been shifted.
// Ports   : Clk         clock, all state on posedge
//           Reset       synchronous active-high reset
//           Load        parallel load of ParallelIn (beats ShiftEn)
//           ParallelIn  load data
//           ShiftEn     perform one shift this cycle
//           Dir         0 = toward MSB, 1 = toward LSB
//           Mode        00 LOGIC, 01 ROTATE, 10 ARITH, 11 HOLD
//           ShiftIn     serial input bit for LOGIC mode
//           ShiftOut    bit that leaves on the next shift (combinational)
//           RegContent  current register value
//           Count       shifts since last load, saturates at WIDTH
//           Done        one-cycle pulse when Count reaches WIDTH
// -----------------------------------------------------------------------------
module universal_shift_reg
    import shift_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Load,
    input  logic [WIDTH-1:0]           ParallelIn,
    input  logic                       ShiftEn,
    input  logic                       Dir,
    input  logic [1:0]                 Mode,
    input  logic                       ShiftIn,
    output logic                       ShiftOut,
    output logic [WIDTH-1:0]           RegContent,
    output logic [$clog2(WIDTH+1)-1:0] Count,
    output logic                       Done
);

    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] w_next;
    logic             w_shift;

    // HOLD is not a shift: neither the data nor the counter moves.
    assign w_shift = ShiftEn && !Load && (Mode != MODE_HOLD);

    always_comb begin
        w_next = r_reg;
        case ({Mode, Dir})
            {MODE_LOGIC,  DIR_LEFT }: w_next = {r_reg[WIDTH-2:0], ShiftIn};
            {MODE_LOGIC,  DIR_RIGHT}: w_next = {ShiftIn, r_reg[WIDTH-1:1]};
            {MODE_ROTATE, DIR_LEFT }: w_next = {r_reg[WIDTH-2:0], r_reg[WIDTH-1]};
            {MODE_ROTATE, DIR_RIGHT}: w_next = {r_reg[0], r_reg[WIDTH-1:1]};
            {MODE_ARITH,  DIR_LEFT }: w_next = {r_reg[WIDTH-2:0], 1'b0};
            {MODE_ARITH,  DIR_RIGHT}: w_next = {r_reg[WIDTH-1], r_reg[WIDTH-1:1]};
            default:                  w_next = r_reg;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            r_reg <= RST_VAL;
        else if (Load)
            r_reg <= ParallelIn;
        else if (w_shift)
            r_reg <= w_next;
    end

    shift_bit_counter #(
        .MAX (WIDTH)
    ) u_counter (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_clear (Load),
        .i_inc   (w_shift),
        .o_count (Count),
        .o_done  (Done)
    );

    // ShiftOut follows Dir immediately so a serializer can present the next
    // bit in the same cycle that Dir changes.
    assign ShiftOut   = Dir ? r_reg[0] : r_reg[WIDTH-1];
    assign RegContent = r_reg;

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         Load = 1'b0;
    logic [W-1:0] ParallelIn = '0;
    logic         ShiftEn = 1'b0;
    logic         Dir = 1'b0;
    logic [1:0]   Mode = 2'b00;
    logic         ShiftIn = 1'b0;
    logic         ShiftOut;
    logic [W-1:0] RegContent;
    logic [3:0]   Count;
    logic         Done;

    universal_shift_reg #(.WIDTH(W), .RST_VAL(8'h00)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Load       (Load),
        .ParallelIn (ParallelIn),
        .ShiftEn    (ShiftEn),
        .Dir        (Dir),
        .Mode       (Mode),
        .ShiftIn    (ShiftIn),
        .ShiftOut   (ShiftOut),
        .RegContent (RegContent),
        .Count      (Count),
        .Done       (Done)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [W-1:0] r;
        logic [3:0]   c;
        logic         d;
    } exp_t;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           done_seen = 0;
    logic [W-1:0] m_reg = '0;
    logic [3:0]   m_cnt = '0;
    logic         m_done = 1'b0;
    logic         last_so;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, advance the reference model, push the
    // expected post-edge state, then pop and compare after the edge.
    task automatic step(input string tag, input logic rst, input logic ld,
                        input logic [W-1:0] pin, input logic sen, input logic dir,
                        input logic [1:0] mode, input logic sin);
        exp_t e;
        exp_t got;
        Reset = rst; Load = ld; ParallelIn = pin; ShiftEn = sen;
        Dir = dir; Mode = mode; ShiftIn = sin;
        #1;
        last_so = ShiftOut;
        check({tag, ".so"}, {31'b0, ShiftOut}, {31'b0, dir ? m_reg[0] : m_reg[W-1]});
        if (rst) begin
            m_reg = 8'h00; m_cnt = 0; m_done = 0;
        end else if (ld) begin
            m_reg = pin; m_cnt = 0; m_done = 0;
        end else if (sen && mode != 2'b11) begin
            case (mode)
                2'b00: m_reg = dir ? {sin, m_reg[7:1]} : {m_reg[6:0], sin};
                2'b01: m_reg = dir ? {m_reg[0], m_reg[7:1]} : {m_reg[6:0], m_reg[7]};
                default: m_reg = dir ? {m_reg[7], m_reg[7:1]} : {m_reg[6:0], 1'b0};
            endcase
            m_done = (m_cnt == 4'd7);
            if (m_cnt < 4'd8) m_cnt = m_cnt + 1;
        end else begin
            m_done = 0;
        end
        e.r = m_reg; e.c = m_cnt; e.d = m_done;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check({tag, ".reg"},  {24'b0, RegContent}, {24'b0, got.r});
            check({tag, ".cnt"},  {28'b0, Count},      {28'b0, got.c});
            check({tag, ".done"}, {31'b0, Done},       {31'b0, got.d});
        end
        if (Done === 1'b1) done_seen++;
        Reset = 0; Load = 0; ShiftEn = 0;
    endtask

    initial begin
        logic [7:0] so_exp;
        logic [7:0] so_got;
        so_exp = 8'hA5;
        @(negedge Clk);

        // 1: reset beats load
        step("rst", 1, 1, 8'hFF, 0, 0, 2'b00, 0);
        check("t1.reg", {24'b0, RegContent}, 32'h00);
        check("t1.cnt", {28'b0, Count}, 32'd0);
        check("t1.done", {31'b0, Done}, 32'd0);

        // 2: logic left serialization of A5
        step("t2.load", 0, 1, 8'hA5, 0, 0, 2'b00, 0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step("t2.sh", 0, 0, 8'h00, 1, 0, 2'b00, 0);
            so_got[7-i] = last_so;
            if (i == 6) check("t2.nodone_early", {31'b0, Done}, 32'd0);
        end
        check("t2.so_seq", {24'b0, so_got}, {24'b0, so_exp});
        check("t2.reg", {24'b0, RegContent}, 32'h00);
        check("t2.cnt8", {28'b0, Count}, 32'd8);
        check("t2.done", {31'b0, Done}, 32'd1);
        step("t2.sh9", 0, 0, 8'h00, 1, 0, 2'b00, 0);
        check("t2.cnt_sat", {28'b0, Count}, 32'd8);
        check("t2.nodone9", {31'b0, Done}, 32'd0);
        check("t2.one_done", done_seen, 32'd1);

        // 3: rotate and hold
        step("t3.load", 0, 1, 8'h81, 0, 0, 2'b00, 0);
        step("t3.rr", 0, 0, 8'h00, 1, 1, 2'b01, 0);
        check("t3.rr", {24'b0, RegContent}, 32'hC0);
        step("t3.rl", 0, 0, 8'h00, 1, 0, 2'b01, 1);
        step("t3.rl", 0, 0, 8'h00, 1, 0, 2'b01, 1);
        check("t3.rl", {24'b0, RegContent}, 32'h03);
        for (int i = 0; i < 3; i++) step("t3.hold", 0, 0, 8'h00, 1, i[0], 2'b11, 1);
        check("t3.hold", {24'b0, RegContent}, 32'h03);
        check("t3.cnt", {28'b0, Count}, 32'd3);

        // 4: arithmetic
        step("t4.load", 0, 1, 8'h90, 0, 0, 2'b00, 0);
        step("t4.ar", 0, 0, 8'h00, 1, 1, 2'b10, 0);
        step("t4.ar", 0, 0, 8'h00, 1, 1, 2'b10, 0);
        check("t4.ar", {24'b0, RegContent}, 32'hE4);
        step("t4.al", 0, 0, 8'h00, 1, 0, 2'b10, 1);
        check("t4.al", {24'b0, RegContent}, 32'hC8);

        // logic right with ShiftIn=1, and idle hold
        step("lr", 0, 0, 8'h00, 1, 1, 2'b00, 1);
        check("lr", {24'b0, RegContent}, 32'hE4);
        step("idle", 0, 0, 8'h00, 0, 0, 2'b00, 1);
        check("idle", {24'b0, RegContent}, 32'hE4);

        // 5: load wins over shift
        step("t5", 0, 1, 8'h3C, 1, 0, 2'b00, 1);
        check("t5.reg", {24'b0, RegContent}, 32'h3C);
        check("t5.cnt", {28'b0, Count}, 32'd0);

        // 6: reset mid-sequence discards it
        step("t6.load", 0, 1, 8'h55, 0, 0, 2'b00, 0);
        done_seen = 0;
        for (int i = 0; i < 5; i++) step("t6.sh", 0, 0, 8'h00, 1, 0, 2'b01, 0);
        step("t6.rst", 1, 0, 8'h00, 0, 0, 2'b00, 0);
        check("t6.nodone_pre", done_seen, 32'd0);
        step("t6.load2", 0, 1, 8'h55, 0, 0, 2'b00, 0);
        for (int i = 0; i < 8; i++) step("t6.sh2", 0, 0, 8'h00, 1, 0, 2'b01, 0);
        check("t6.reg", {24'b0, RegContent}, 32'h55);
        step("t6.extra", 0, 0, 8'h00, 1, 1, 2'b01, 0);
        check("t6.one_done", done_seen, 32'd1);

        // load on the Done cycle clears it next edge
        step("t7.load", 0, 1, 8'h01, 0, 0, 2'b00, 0);
        for (int i = 0; i < 8; i++) step("t7.sh", 0, 0, 8'h00, 1, 1, 2'b00, 0);
        check("t7.done", {31'b0, Done}, 32'd1);
        step("t7.ld_on_done", 0, 1, 8'hAA, 0, 0, 2'b00, 0);
        check("t7.cleared", {31'b0, Done}, 32'd0);
        check("t7.reg", {24'b0, RegContent}, 32'hAA);

        check("sb.drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
